// File: rtl/calc_pkg.sv
// Shared key codes, opcode and controller state types for calc_op_engine.
package calc_pkg;

  localparam logic [3:0] KEY_LOAD_A = 4'd0;
  localparam logic [3:0] KEY_LOAD_B = 4'd1;
  localparam logic [3:0] KEY_ADD    = 4'd2;
  localparam logic [3:0] KEY_SUB    = 4'd3;
  localparam logic [3:0] KEY_MUL    = 4'd4;
  localparam logic [3:0] KEY_DIV    = 4'd5;
  localparam logic [3:0] KEY_EXEC   = 4'd6;
  localparam logic [3:0] KEY_MOD    = 4'd7;
  localparam logic [3:0] KEY_CLEAR  = 4'd8;

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_DIV,
    OP_MOD
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DIV
  } state_e;

  function automatic logic is_div_op(input op_e op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/calc_seq_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, DATA_W cycles after start.
module calc_seq_divider #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic              done_o,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              run_q, run_d;
  logic              done_q, done_d;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;

  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    done_d  = 1'b0;
    shifted = {rem_q, quo_q[DATA_W-1]};
    trial   = shifted - {1'b0, dvs_q};
    if (abort_i) begin
      run_d = 1'b0;
    end else if (start_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      // A borrow out of the trial subtraction means the divisor did not fit.
      rem_d = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
      quo_d = {quo_q[DATA_W-2:0], ~trial[DATA_W]};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(DATA_W - 1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done_o      = done_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/calc_op_engine.sv
// Calculator operation controller: key-driven operand/opcode latching, single-cycle
// add/sub/mul, sequential divide. Define CALC_MOD_EN to enable the MOD key (7).
module calc_op_engine
  import calc_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RES_W  = 2 * DATA_W,
  parameter int unsigned SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        key,
  input  logic              key_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic [RES_W-1:0]  result,
  output logic              result_valid,
  output logic              busy,
  output logic              overflow,
  output logic              div_error
);

  localparam bit IS_SIGNED = (SIGNED != 0);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [RES_W-1:0]  res_q, res_d;
  logic              ovf_q, ovf_d;
  logic              dive_q, dive_d;
  logic              valid_q, valid_d;

  logic              div_start, div_abort, div_done;
  logic [DATA_W-1:0] div_quo, div_rem;

  logic              a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [RES_W-1:0]  a_ext, b_ext;
  logic [RES_W-1:0]  alu_res, div_res, quo_u;

  assign a_neg = IS_SIGNED && opa_q[DATA_W-1];
  assign b_neg = IS_SIGNED && opb_q[DATA_W-1];
  assign a_ext = {{(RES_W-DATA_W){a_neg}}, opa_q};
  assign b_ext = {{(RES_W-DATA_W){b_neg}}, opb_q};
  assign a_mag = a_neg ? -opa_q : opa_q;
  assign b_mag = b_neg ? -opb_q : opb_q;
  assign quo_u = {{(RES_W-DATA_W){1'b0}}, div_quo};

  // Both operands are extended to RES_W, so the low RES_W bits of the product are exact.
  always_comb begin
    alu_res = a_ext + b_ext;
    case (op_q)
      OP_SUB:  alu_res = a_ext - b_ext;
      OP_MUL:  alu_res = a_ext * b_ext;
      default: ;
    endcase
  end

`ifdef CALC_MOD_EN
  logic [RES_W-1:0] rem_u;
  assign rem_u = {{(RES_W-DATA_W){1'b0}}, div_rem};

  always_comb begin
    if (op_q == OP_MOD) begin
      div_res = a_neg ? -rem_u : rem_u;
    end else begin
      div_res = (a_neg ^ b_neg) ? -quo_u : quo_u;
    end
  end
`else
  logic unused_rem;
  assign unused_rem = ^div_rem;
  assign div_res    = (a_neg ^ b_neg) ? -quo_u : quo_u;
`endif

  // True results always fit in RES_W, so range is judged from the stored bits.
  function automatic logic ovf_of(input logic [RES_W-1:0] v);
    if (IS_SIGNED) begin
      return !((&v[RES_W-1:DATA_W-1]) || !(|v[RES_W-1:DATA_W-1]));
    end
    return |v[RES_W-1:DATA_W];
  endfunction

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    ovf_d     = ovf_q;
    dive_d    = dive_q;
    valid_d   = 1'b0;
    div_start = 1'b0;
    div_abort = 1'b0;
    if (key_valid && key == KEY_CLEAR) begin
      state_d   = ST_IDLE;
      op_d      = OP_ADD;
      opa_d     = '0;
      opb_d     = '0;
      res_d     = '0;
      ovf_d     = 1'b0;
      dive_d    = 1'b0;
      div_abort = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_valid) begin
            case (key)
              KEY_LOAD_A: opa_d = data_in;
              KEY_LOAD_B: opb_d = data_in;
              KEY_ADD:    op_d  = OP_ADD;
              KEY_SUB:    op_d  = OP_SUB;
              KEY_MUL:    op_d  = OP_MUL;
              KEY_DIV:    op_d  = OP_DIV;
`ifdef CALC_MOD_EN
              KEY_MOD:    op_d  = OP_MOD;
`endif
              KEY_EXEC: begin
                if (is_div_op(op_q) && opb_q != '0) begin
                  state_d   = ST_DIV;
                  div_start = 1'b1;
                end else begin
                  state_d = ST_EXEC;
                end
              end
              default: ;
            endcase
          end
        end
        ST_EXEC: begin
          state_d = ST_IDLE;
          valid_d = 1'b1;
          if (is_div_op(op_q)) begin
            res_d  = '0;
            ovf_d  = 1'b0;
            dive_d = 1'b1;
          end else begin
            res_d  = alu_res;
            ovf_d  = ovf_of(alu_res);
            dive_d = 1'b0;
          end
        end
        ST_DIV: begin
          if (div_done) begin
            state_d = ST_IDLE;
            valid_d = 1'b1;
            res_d   = div_res;
            ovf_d   = ovf_of(div_res);
            dive_d  = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      dive_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      dive_q  <= dive_d;
      valid_q <= valid_d;
    end
  end

  calc_seq_divider #(
    .DATA_W(DATA_W)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start),
    .abort_i    (div_abort),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .done_o     (div_done),
    .quotient_o (div_quo),
    .remainder_o(div_rem)
  );

  assign result       = res_q;
  assign result_valid = valid_q;
  assign busy         = (state_q != ST_IDLE);
  assign overflow     = ovf_q;
  assign div_error    = dive_q;

endmodule

// File: tb/tb_calc_op_engine.sv
// Bench for calc_op_engine: unsigned and signed instances share one key stream and are
// checked against an arithmetic reference model. Honours CALC_MOD_EN like the RTL.
module tb_calc_op_engine;

  localparam int unsigned W  = 8;
  localparam int unsigned RW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    key;
  logic          key_valid;
  logic [W-1:0]  data_in;
  logic [RW-1:0] res_u, res_s;
  logic          rv_u, rv_s, busy_u, busy_s, ovf_u, ovf_s, de_u, de_s;

  always #5 clk = ~clk;

  calc_op_engine #(.DATA_W(W), .RES_W(RW), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .key(key), .key_valid(key_valid), .data_in(data_in),
    .result(res_u), .result_valid(rv_u), .busy(busy_u), .overflow(ovf_u), .div_error(de_u)
  );

  calc_op_engine #(.DATA_W(W), .RES_W(RW), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .key(key), .key_valid(key_valid), .data_in(data_in),
    .result(res_s), .result_valid(rv_s), .busy(busy_s), .overflow(ovf_s), .div_error(de_s)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: raw operand bytes and the selected operation as its key code.
  int mA, mB, mOp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input int v, input bit sgn);
    return (sgn && v >= 128) ? longint'(v) - 256 : longint'(v);
  endfunction

  task automatic model_reset();
    mA = 0; mB = 0; mOp = 2;
  endtask

  task automatic model_exec(input bit sgn, output logic [RW-1:0] r, output logic o,
                            output logic d, output int lat);
    longint a, b, v;
    a = sx(mA, sgn);
    b = sx(mB, sgn);
    d = 1'b0;
    lat = 1;
    case (mOp)
      2: v = a + b;
      3: v = a - b;
      4: v = a * b;
      default: begin
        if (b == 0) begin
          v = 0;
          d = 1'b1;
        end else begin
          v = (mOp == 5) ? a / b : a % b;
          lat = W + 1;
        end
      end
    endcase
    r = v[RW-1:0];
    if (d) o = 1'b0;
    else if (sgn) o = (v < -128) || (v > 127);
    else o = (v < 0) || (v > 255);
  endtask

  // Called at a negedge; the key is accepted at the next posedge, returns at the following negedge.
  task automatic press(input int k, input int d);
    key = 4'(k);
    data_in = W'(d);
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    case (k)
      0: mA = d & 255;
      1: mB = d & 255;
      2, 3, 4, 5: mOp = k;
`ifdef CALC_MOD_EN
      7: mOp = 7;
`endif
      8: model_reset();
      default: ;
    endcase
  endtask

  task automatic do_exec(input string tag, input bit inject);
    logic [RW-1:0] er_u, er_s;
    logic eo_u, eo_s, ed_u, ed_s;
    int el_u, el_s, k;
    model_exec(1'b0, er_u, eo_u, ed_u, el_u);
    model_exec(1'b1, er_s, eo_s, ed_s, el_s);
    press(6, 0);
    chk({tag, ".busy_hi"}, busy_u, 1);
    k = 0;
    while (k < 40) begin
      // Loads and opcode selects while busy must have no effect.
      if (inject && k >= 1 && k <= 3) begin
        key = (k == 1) ? 4'd0 : (k == 2) ? 4'd1 : 4'd3;
        data_in = W'($urandom);
        key_valid = 1'b1;
      end else begin
        key_valid = 1'b0;
      end
      @(negedge clk);
      k++;
      if (rv_u) break;
    end
    key_valid = 1'b0;
    chk({tag, ".lat"}, k, el_u);
    chk({tag, ".rv_s"}, rv_s, 1);
    chk({tag, ".res_u"}, res_u, er_u);
    chk({tag, ".ovf_u"}, ovf_u, eo_u);
    chk({tag, ".de_u"}, de_u, ed_u);
    chk({tag, ".res_s"}, res_s, er_s);
    chk({tag, ".ovf_s"}, ovf_s, eo_s);
    chk({tag, ".de_s"}, de_s, ed_s);
    chk({tag, ".busy_lo"}, busy_u | busy_s, 0);
    @(negedge clk);
    chk({tag, ".pulse"}, rv_u | rv_s, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".res"}, {res_u, res_s}, 0);
    chk({tag, ".flags"}, {rv_u, rv_s, busy_u, busy_s, ovf_u, ovf_s, de_u, de_s}, 0);
  endtask

  initial begin
    int corner[6];
    int a, b, cnt;
    corner = '{0, 1, 2, 127, 128, 255};
    rst_n = 1'b0;
    key = '0;
    key_valid = 1'b0;
    data_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    press(0, 200); press(1, 100); press(2, 0);
    do_exec("add_200_100", 1'b0);

    press(0, 5); press(1, 7); press(3, 0);
    do_exec("sub_5_7", 1'b0);
    press(0, 15); press(1, 17); press(4, 0);
    do_exec("mul_15_17", 1'b0);
    press(0, 16); press(1, 16);
    do_exec("mul_16_16", 1'b0);

    press(0, 200); press(1, 7); press(5, 0);
    do_exec("div_200_7_busykeys", 1'b1);
    do_exec("div_repeat", 1'b0);

    press(0, 9); press(1, 0);
    do_exec("div_by_zero", 1'b0);
    press(1, 3);
    do_exec("div_9_3", 1'b0);

    // Abort an in-flight divide with CLEAR three edges after the execute edge.
    press(0, 200); press(1, 7);
    press(6, 0);
    repeat (2) @(negedge clk);
    press(8, 0);
    check_zero("clear");
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rv_u || rv_s) cnt++;
    end
    chk("clear.no_pulse", cnt, 0);
    do_exec("after_clear", 1'b0);

    press(0, 50); press(1, 60);
    do_exec("add_50_60", 1'b0);
    press(6, 0);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    do_exec("after_reset", 1'b0);

    press(0, 128); press(1, 255); press(5, 0);
    do_exec("div_min_m1", 1'b0);
`ifdef CALC_MOD_EN
    press(0, 249); press(1, 2); press(7, 0);
    do_exec("mod_m7_2", 1'b0);
    press(1, 0);
    do_exec("mod_by_zero", 1'b0);
`else
    press(0, 249); press(1, 2); press(2, 0); press(7, 0);
    do_exec("key7_ignored", 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : int'($urandom_range(0, 255));
      b = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : int'($urandom_range(0, 255));
      if ($urandom_range(0, 4) != 0) press(0, a);
      if ($urandom_range(0, 4) != 0) press(1, b);
`ifdef CALC_MOD_EN
      press(int'($urandom_range(2, 6)) == 6 ? 7 : int'($urandom_range(2, 5)), 0);
`else
      press(int'($urandom_range(2, 5)), 0);
`endif
      do_exec($sformatf("rand%0d", i), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
